sudoku_front_panel: RTL

- Parametrised successor to the board-level status logic: one block owning all operator I/O for the solver.
- Debounces raw push-buttons, issues single-cycle start pulses to the grid, and tracks run status (idle / running / success / failure).
- Latches a cursor-position snapshot on demand and cycles the occupancy-mask view mode.
- Drives active-low seven-segment digits and the mask LEDs; sized for any grid order.

---
 rtl/sudoku_pkg.sv | 34 +++
 rtl/sudoku_front_panel_key_debounce.sv | 61 ++++++
 rtl/sudoku_front_panel.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/sudoku_pkg.sv
// Shared types and seven-segment constants for the solver front panel.
// Segment order is {g,f,e,d,c,b,a}, active-low (0 lights a segment).
package sudoku_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_DASH  = 7'b0111111;
    localparam seg7_t SEG_BLANK = 7'b1111111;
    localparam seg7_t SEG_S     = 7'b0010010;
    localparam seg7_t SEG_F     = 7'b0001110;
    localparam seg7_t SEG_R     = 7'b0101111;
    localparam seg7_t SEG_C     = 7'b0100111;
    localparam seg7_t SEG_B     = 7'b0000011;

    // Hex digits 0..F
    localparam seg7_t SEG_HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic [1:0] {
        VIEW_ROW,
        VIEW_COL,
        VIEW_BLK
    } view_mode_e;

    typedef enum logic [1:0] {
        IDLE,
        RUNNING,
        DONE_OK,
        DONE_FAIL
    } panel_state_e;

endpackage

// File: rtl/sudoku_front_panel_key_debounce.sv
// Per-key debouncer: 2-flop synchroniser, stability counter, press pulse.
// Ports: clock, reset (sync, active-high), key_n (raw, active-low),
//        pressed (accepted level), press_pulse (one cycle on accepted press).
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic key_n,
    output logic pressed,
    output logic press_pulse
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             acc_n_q, acc_n_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             pulse_q, pulse_d;

    // Accepted level flips one cycle after the count has reached the limit
    always_comb begin
        sync1_d = key_n;
        sync2_d = sync1_q;
        acc_n_d = acc_n_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        if (sync2_q == acc_n_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES)) begin
            acc_n_d = ~acc_n_q;
            cnt_d   = '0;
            // Only the released->pressed flip is an event
            pulse_d = acc_n_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Reset treats the key as pressed so a held key cannot fire on release of reset
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            acc_n_q <= 1'b0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            acc_n_q <= acc_n_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign pressed     = ~acc_n_q;
    assign press_pulse = pulse_q;

endmodule

// File: rtl/sudoku_front_panel.sv
// Operator front panel for the solver: debounced keys, start pulse, run status,
// cursor snapshot, mask view mode and seven-segment / LED drive.
// Ports: clock, reset (sync, active-high), key_n[2:0] ({mode,snapshot,start}),
//        done_success/done_failure, cursor_row/col, row/col/blk_mask in;
//        start, ledr, hex_status, hex_mode, hex_row, hex_col out (all registered).
module sudoku_front_panel
    import sudoku_pkg::*;
#(
    parameter int unsigned ORDER           = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned BLINK_CYCLES    = 12_500_000
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [2:0]                        key_n,
    input  logic                              done_success,
    input  logic                              done_failure,
    input  logic [$clog2(ORDER*ORDER)-1:0]    cursor_row,
    input  logic [$clog2(ORDER*ORDER)-1:0]    cursor_col,
    input  logic [ORDER*ORDER-1:0]            row_mask,
    input  logic [ORDER*ORDER-1:0]            col_mask,
    input  logic [ORDER*ORDER-1:0]            blk_mask,
    output logic                              start,
    output logic [ORDER*ORDER-1:0]            ledr,
    output logic [6:0]                        hex_status,
    output logic [6:0]                        hex_mode,
    output logic [6:0]                        hex_row,
    output logic [6:0]                        hex_col
);

    localparam int unsigned LENGTH  = ORDER * ORDER;
    localparam int unsigned POS_W   = $clog2(LENGTH);
    localparam int unsigned BLINK_W = $clog2(BLINK_CYCLES + 1);

    logic [2:0] key_press;
    logic [2:0] unused_key_held;

    // Key debouncers: [0]=start, [1]=snapshot, [2]=view mode
    for (genvar i = 0; i < 3; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clock      (clock),
            .reset      (reset),
            .key_n      (key_n[i]),
            .pressed    (unused_key_held[i]),
            .press_pulse(key_press[i])
        );
    end

    panel_state_e       state_q,       state_d;
    logic               start_q,       start_d;
    logic [BLINK_W-1:0] blink_cnt_q,   blink_cnt_d;
    logic               blink_phase_q, blink_phase_d;
    seg7_t              hex_status_q,  hex_status_d;
    logic [POS_W-1:0]   snap_row_q,    snap_row_d;
    logic [POS_W-1:0]   snap_col_q,    snap_col_d;
    seg7_t              hex_row_q,     hex_row_d;
    seg7_t              hex_col_q,     hex_col_d;
    view_mode_e         mode_q,        mode_d;
    seg7_t              hex_mode_q,    hex_mode_d;
    logic [LENGTH-1:0]  ledr_q,        ledr_d;

    // Run FSM, blink timer, snapshot, view mode and display encoding
    always_comb begin
        state_d       = state_q;
        start_d       = 1'b0;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        snap_row_d    = snap_row_q;
        snap_col_d    = snap_col_q;
        mode_d        = mode_q;
        hex_status_d  = SEG_DASH;
        ledr_d        = row_mask;
        hex_mode_d    = SEG_R;

        case (state_q)
            RUNNING: begin
                // Success wins when both done inputs rise together
                if (done_success) begin
                    state_d = DONE_OK;
                end else if (done_failure) begin
                    state_d = DONE_FAIL;
                end
                if (blink_cnt_q == BLINK_W'(BLINK_CYCLES - 1)) begin
                    blink_cnt_d   = '0;
                    blink_phase_d = ~blink_phase_q;
                end else begin
                    blink_cnt_d = blink_cnt_q + 1'b1;
                end
            end
            default: begin
                if (key_press[0]) begin
                    start_d       = 1'b1;
                    state_d       = RUNNING;
                    blink_cnt_d   = '0;
                    blink_phase_d = 1'b0;
                end
            end
        endcase

        case (state_d)
            RUNNING:   hex_status_d = blink_phase_d ? SEG_BLANK : SEG_DASH;
            DONE_OK:   hex_status_d = SEG_S;
            DONE_FAIL: hex_status_d = SEG_F;
            default:   hex_status_d = SEG_DASH;
        endcase

        if (key_press[1]) begin
            snap_row_d = cursor_row;
            snap_col_d = cursor_col;
        end
        hex_row_d = SEG_HEX[4'(snap_row_d)];
        hex_col_d = SEG_HEX[4'(snap_col_d)];

        if (key_press[2]) begin
            case (mode_q)
                VIEW_ROW: mode_d = VIEW_COL;
                VIEW_COL: mode_d = VIEW_BLK;
                default:  mode_d = VIEW_ROW;
            endcase
        end

        case (mode_d)
            VIEW_COL: hex_mode_d = SEG_C;
            VIEW_BLK: hex_mode_d = SEG_B;
            default:  hex_mode_d = SEG_R;
        endcase

        // LEDs follow the current mode register, so a mode change lags one cycle
        case (mode_q)
            VIEW_COL: ledr_d = col_mask;
            VIEW_BLK: ledr_d = blk_mask;
            default:  ledr_d = row_mask;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            start_q       <= 1'b0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            hex_status_q  <= SEG_DASH;
            snap_row_q    <= '0;
            snap_col_q    <= '0;
            hex_row_q     <= SEG_HEX[0];
            hex_col_q     <= SEG_HEX[0];
            mode_q        <= VIEW_ROW;
            hex_mode_q    <= SEG_R;
            ledr_q        <= '0;
        end else begin
            state_q       <= state_d;
            start_q       <= start_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            hex_status_q  <= hex_status_d;
            snap_row_q    <= snap_row_d;
            snap_col_q    <= snap_col_d;
            hex_row_q     <= hex_row_d;
            hex_col_q     <= hex_col_d;
            mode_q        <= mode_d;
            hex_mode_q    <= hex_mode_d;
            ledr_q        <= ledr_d;
        end
    end

    assign start      = start_q;
    assign ledr       = ledr_q;
    assign hex_status = hex_status_q;
    assign hex_mode   = hex_mode_q;
    assign hex_row    = hex_row_q;
    assign hex_col    = hex_col_q;

endmodule
